calc_op_sequencer: RTL and testbench

CALC_OP_SEQUENCER -- requirements
Module: calc_op_sequencer

---
 rtl/calc_op_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_calc_op_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_op_sequencer.sv
// calc_op_sequencer: menu-driven operation selector and sequencer for an
// external ALU datapath. Buttons pick an operation, enter launches it with
// the latched operand switches, and the result or an error code is shown.
//
// ALU handshake: alu_start is a one-cycle request carrying alu_op/alu_a/
// alu_b, which stay stable until the next launch. The datapath answers
// with a one-cycle alu_done strobe; alu_err and alu_result are only
// meaningful in that cycle. A completion is accepted only in WAIT; any
// strobe outside WAIT, including a late one after an abort, is dropped.
module calc_op_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       up,
    input  logic       down,
    input  logic       enter,
    input  logic       back,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       alu_done,
    input  logic       alu_err,
    input  logic [7:0] alu_result,
    output logic [2:0] alu_op,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic       alu_start,
    output logic [7:0] disp_val,
    output logic [1:0] disp_mode,
    output logic       busy,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        S_MENU   = 3'd0,
        S_START  = 3'd1,
        S_WAIT   = 3'd2,
        S_RESULT = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    localparam logic [1:0] MODE_MENU   = 2'd0;
    localparam logic [1:0] MODE_BUSY   = 2'd1;
    localparam logic [1:0] MODE_RESULT = 2'd2;
    localparam logic [1:0] MODE_ERROR  = 2'd3;
    localparam logic [7:0] ERR_CODE    = 8'hEE;
    // Last WAIT count before the counter reaches 255 and the wait expires.
    localparam logic [7:0] TMO_LAST    = 8'd254;

    state_t     state_q;
    logic [2:0] op_idx_q, op_idx_d;
    logic [7:0] tmo_q;
    logic       up_hist_q, down_hist_q, enter_hist_q, back_hist_q;
    logic [2:0] alu_op_q;
    logic [3:0] alu_a_q, alu_b_q;
    logic       alu_start_q, busy_q;
    logic [7:0] disp_val_q;
    logic [1:0] disp_mode_q;

    logic raw_up, raw_down, raw_enter, raw_back;
    logic ev_up, ev_down, ev_enter, ev_back;

    // Rising-edge detection against last cycle's button levels.
    assign raw_up    = up    & ~up_hist_q;
    assign raw_down  = down  & ~down_hist_q;
    assign raw_enter = enter & ~enter_hist_q;
    assign raw_back  = back  & ~back_hist_q;

    // One event per cycle: back > enter > up > down, losers are dropped.
    assign ev_back  = raw_back;
    assign ev_enter = raw_enter & ~raw_back;
    assign ev_up    = raw_up    & ~raw_back & ~raw_enter;
    assign ev_down  = raw_down  & ~raw_back & ~raw_enter & ~raw_up;

    // Menu cursor next value, wrapping naturally in 3 bits.
    always_comb begin
        op_idx_d = op_idx_q;
        if (ev_up) begin
            op_idx_d = op_idx_q + 3'd1;
        end else if (ev_down) begin
            op_idx_d = op_idx_q - 3'd1;
        end
    end

    // Button history; reset high so a button held through reset is ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            up_hist_q    <= 1'b1;
            down_hist_q  <= 1'b1;
            enter_hist_q <= 1'b1;
            back_hist_q  <= 1'b1;
        end else begin
            up_hist_q    <= up;
            down_hist_q  <= down;
            enter_hist_q <= enter;
            back_hist_q  <= back;
        end
    end

    // Sequencer FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_MENU;
            op_idx_q    <= 3'd0;
            tmo_q       <= 8'd0;
            alu_op_q    <= 3'd0;
            alu_a_q     <= 4'd0;
            alu_b_q     <= 4'd0;
            alu_start_q <= 1'b0;
            busy_q      <= 1'b0;
            disp_val_q  <= 8'd0;
            disp_mode_q <= MODE_MENU;
        end else begin
            case (state_q)
                S_MENU: begin
                    if (ev_enter) begin
                        alu_a_q     <= a;
                        alu_b_q     <= b;
                        alu_op_q    <= op_idx_q;
                        alu_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                        disp_mode_q <= MODE_BUSY;
                        state_q     <= S_START;
                    end else if (ev_up || ev_down) begin
                        op_idx_q   <= op_idx_d;
                        disp_val_q <= {5'b0, op_idx_d};
                    end
                end
                S_START: begin
                    alu_start_q <= 1'b0;
                    tmo_q       <= 8'd0;
                    state_q     <= S_WAIT;
                end
                S_WAIT: begin
                    tmo_q <= tmo_q + 8'd1;
                    if (ev_back) begin
                        busy_q      <= 1'b0;
                        disp_val_q  <= {5'b0, op_idx_q};
                        disp_mode_q <= MODE_MENU;
                        state_q     <= S_MENU;
                    end else if (alu_done && !alu_err) begin
                        busy_q      <= 1'b0;
                        disp_val_q  <= alu_result;
                        disp_mode_q <= MODE_RESULT;
                        state_q     <= S_RESULT;
                    end else if (alu_done || tmo_q == TMO_LAST) begin
                        busy_q      <= 1'b0;
                        disp_val_q  <= ERR_CODE;
                        disp_mode_q <= MODE_ERROR;
                        state_q     <= S_ERROR;
                    end
                end
                S_RESULT: begin
                    if (ev_back) begin
                        disp_val_q  <= {5'b0, op_idx_q};
                        disp_mode_q <= MODE_MENU;
                        state_q     <= S_MENU;
                    end else if (ev_enter) begin
                        alu_a_q     <= a;
                        alu_b_q     <= b;
                        alu_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                        disp_mode_q <= MODE_BUSY;
                        state_q     <= S_START;
                    end
                end
                S_ERROR: begin
                    if (ev_back || ev_enter) begin
                        disp_val_q  <= {5'b0, op_idx_q};
                        disp_mode_q <= MODE_MENU;
                        state_q     <= S_MENU;
                    end
                end
                default: begin
                    alu_start_q <= 1'b0;
                    busy_q      <= 1'b0;
                    disp_val_q  <= {5'b0, op_idx_q};
                    disp_mode_q <= MODE_MENU;
                    state_q     <= S_MENU;
                end
            endcase
        end
    end

    assign alu_op    = alu_op_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_start = alu_start_q;
    assign busy      = busy_q;
    assign disp_val  = disp_val_q;
    assign disp_mode = disp_mode_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Bench for calc_op_sequencer: scenario tasks drive buttons and act as the
// ALU datapath; expected display values go through a scoreboard queue.
module tb_calc_op_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       up = 1'b0, down = 1'b0, enter = 1'b0, back = 1'b0;
  logic [3:0] a = 4'd0, b = 4'd0;
  logic       alu_done = 1'b0, alu_err = 1'b0;
  logic [7:0] alu_result = 8'd0;
  logic [2:0] alu_op;
  logic [3:0] alu_a, alu_b;
  logic       alu_start;
  logic [7:0] disp_val;
  logic [1:0] disp_mode;
  logic       busy;
  logic [2:0] state_dbg;

  int n_checks = 0;
  int n_pass = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_v;
  logic [2:0] exp_idx;

  calc_op_sequencer dut (
    .clk(clk), .rst(rst), .up(up), .down(down), .enter(enter), .back(back),
    .a(a), .b(b), .alu_done(alu_done), .alu_err(alu_err), .alu_result(alu_result),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_start(alu_start),
    .disp_val(disp_val), .disp_mode(disp_mode), .busy(busy), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    {up, down, enter, back} = 4'b0;
    alu_done = 1'b0; alu_err = 1'b0; alu_result = 8'd0;
    tick(); tick();
    rst = 1'b1;
    exp_idx = 3'd0;
  endtask

  // driver tasks
  task automatic set_btn(input int code, input logic v);
    case (code)
      0: up = v;
      1: down = v;
      2: enter = v;
      default: back = v;
    endcase
  endtask

  // Returns one cycle after the edge that saw the press, button released.
  task automatic press(input int code);
    set_btn(code, 1'b0);
    tick();
    set_btn(code, 1'b1);
    tick();
    set_btn(code, 1'b0);
  endtask

  task automatic alu_pulse(input logic err, input logic [7:0] res);
    alu_done = 1'b1; alu_err = err; alu_result = res;
    tick();
    alu_done = 1'b0; alu_err = 1'b0; alu_result = 8'd0;
  endtask

  task automatic wait_mode(input logic [1:0] m, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (disp_mode === m) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  function automatic logic [7:0] alu_ref(input logic [2:0] op, input logic [3:0] x, input logic [3:0] y);
    case (op)
      3'd0: alu_ref = {4'b0, x} + {4'b0, y};
      3'd1: alu_ref = {4'b0, x} - {4'b0, y};
      3'd2: alu_ref = {4'b0, x} * {4'b0, y};
      3'd3: alu_ref = {4'b0, x} / {4'b0, y};
      3'd4: alu_ref = {4'b0, x & y};
      3'd5: alu_ref = {4'b0, x | y};
      3'd6: alu_ref = {4'b0, x ^ y};
      default: alu_ref = {4'b0, ~x};
    endcase
  endfunction

  task automatic test_reset();
    do_reset();
    tick();
    rst = 1'b0;
    #2;
    n_checks++; if (alu_start !== 1'b0 || busy !== 1'b0) $display("FAIL reset_ctl: got start=%b busy=%b exp 0 0", alu_start, busy); else n_pass++;
    n_checks++; if (disp_val !== 8'd0 || disp_mode !== 2'd0) $display("FAIL reset_disp: got %h/%0d exp 00/0", disp_val, disp_mode); else n_pass++;
    n_checks++; if ({alu_op, alu_a, alu_b} !== 11'd0) $display("FAIL reset_alu: got op=%0d a=%0d b=%0d exp 0", alu_op, alu_a, alu_b); else n_pass++;
    n_checks++; if (state_dbg !== 3'd0) $display("FAIL reset_state: got %0d exp 0", state_dbg); else n_pass++;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_mul();
    bit ok;
    do_reset();
    press(0);
    n_checks++; if (disp_val !== 8'd1) $display("FAIL mul_up1: got %0d exp 1", disp_val); else n_pass++;
    press(0);
    n_checks++; if (disp_val !== 8'd2 || disp_mode !== 2'd0) $display("FAIL mul_up2: got %0d/%0d exp 2/0", disp_val, disp_mode); else n_pass++;
    a = 4'd10; b = 4'd15;
    press(2);
    n_checks++; if (alu_op !== 3'd2 || alu_a !== 4'd10 || alu_b !== 4'd15) $display("FAIL mul_latch: got op=%0d a=%0d b=%0d exp 2 10 15", alu_op, alu_a, alu_b); else n_pass++;
    n_checks++; if (alu_start !== 1'b1 || busy !== 1'b1) $display("FAIL mul_start: got start=%b busy=%b exp 1 1", alu_start, busy); else n_pass++;
    a = 4'd0; b = 4'd0;
    tick();
    n_checks++; if (alu_start !== 1'b0 || busy !== 1'b1 || disp_mode !== 2'd1) $display("FAIL mul_wait: got start=%b busy=%b mode=%0d exp 0 1 1", alu_start, busy, disp_mode); else n_pass++;
    n_checks++; if (alu_a !== 4'd10 || alu_b !== 4'd15) $display("FAIL mul_hold: got a=%0d b=%0d exp 10 15", alu_a, alu_b); else n_pass++;
    tick(); tick();
    exp_q.push_back(alu_ref(3'd2, 4'd10, 4'd15));
    alu_pulse(1'b0, alu_ref(3'd2, 4'd10, 4'd15));
    wait_mode(2'd2, ok);
    n_checks++; if (!ok) $display("FAIL mul_timeout: got mode=%0d exp 2", disp_mode); else n_pass++;
    exp_v = exp_q.pop_front();
    n_checks++; if (disp_val !== exp_v || busy !== 1'b0) $display("FAIL mul_result: got %h busy=%b exp %h 0", disp_val, busy, exp_v); else n_pass++;
    n_checks++; if (exp_v !== 8'h96) $display("FAIL mul_model: got %h exp 96", exp_v); else n_pass++;
  endtask

  task automatic test_menu_wrap();
    do_reset();
    press(1);
    n_checks++; if (disp_val !== 8'd7) $display("FAIL wrap_down: got %0d exp 7", disp_val); else n_pass++;
    press(0);
    n_checks++; if (disp_val !== 8'd0) $display("FAIL wrap_up: got %0d exp 0", disp_val); else n_pass++;
    tick();
    up = 1'b1; down = 1'b1;
    tick();
    up = 1'b0; down = 1'b0;
    n_checks++; if (disp_val !== 8'd1) $display("FAIL prio_updown: got %0d exp 1", disp_val); else n_pass++;
    press(3);
    n_checks++; if (disp_val !== 8'd1 || disp_mode !== 2'd0 || busy !== 1'b0) $display("FAIL menu_back: got %0d/%0d busy=%b exp 1/0 0", disp_val, disp_mode, busy); else n_pass++;
    tick();
    enter = 1'b1; up = 1'b1;
    tick();
    enter = 1'b0; up = 1'b0;
    n_checks++; if (alu_start !== 1'b1 || alu_op !== 3'd1) $display("FAIL prio_enter: got start=%b op=%0d exp 1 1", alu_start, alu_op); else n_pass++;
    press(3);
    n_checks++; if (disp_mode !== 2'd0 || disp_val !== 8'd1) $display("FAIL prio_keep: got %0d/%0d exp 0/1", disp_mode, disp_val); else n_pass++;
  endtask

  task automatic test_timeout();
    int waits;
    do_reset();
    press(2);
    waits = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (disp_mode === 2'd3) break;
      if (busy === 1'b1 && alu_start === 1'b0) waits++;
    end
    n_checks++; if (waits !== 255) $display("FAIL tmo_cycles: got %0d exp 255", waits); else n_pass++;
    n_checks++; if (disp_val !== 8'hEE || disp_mode !== 2'd3 || busy !== 1'b0) $display("FAIL tmo_err: got %h/%0d busy=%b exp ee/3 0", disp_val, disp_mode, busy); else n_pass++;
    press(3);
    n_checks++; if (disp_mode !== 2'd0 || disp_val !== 8'd0) $display("FAIL tmo_back: got %0d/%h exp 0/00", disp_mode, disp_val); else n_pass++;
    // completion in the final WAIT cycle beats the timeout
    press(2);
    for (int i = 0; i < 255; i++) tick();
    n_checks++; if (disp_mode !== 2'd1) $display("FAIL tmo_edge_wait: got mode=%0d exp 1", disp_mode); else n_pass++;
    exp_q.push_back(8'h5A);
    alu_pulse(1'b0, 8'h5A);
    exp_v = exp_q.pop_front();
    n_checks++; if (disp_mode !== 2'd2 || disp_val !== exp_v) $display("FAIL tmo_done_wins: got %0d/%h exp 2/%h", disp_mode, disp_val, exp_v); else n_pass++;
  endtask

  task automatic test_div_err();
    bit ok;
    do_reset();
    for (int i = 0; i < 5; i++) press(1);
    n_checks++; if (disp_val !== 8'd3) $display("FAIL div_sel: got %0d exp 3", disp_val); else n_pass++;
    a = 4'd9; b = 4'd0;
    press(2);
    n_checks++; if (alu_op !== 3'd3 || alu_b !== 4'd0 || alu_a !== 4'd9) $display("FAIL div_latch: got op=%0d a=%0d b=%0d exp 3 9 0", alu_op, alu_a, alu_b); else n_pass++;
    tick(); tick();
    exp_q.push_back(8'hEE);
    alu_pulse(1'b1, 8'h00);
    wait_mode(2'd3, ok);
    exp_v = exp_q.pop_front();
    n_checks++; if (!ok || disp_val !== exp_v) $display("FAIL div_err: got %0d/%h exp 3/%h", disp_mode, disp_val, exp_v); else n_pass++;
    press(2);
    n_checks++; if (disp_mode !== 2'd0 || disp_val !== 8'd3 || alu_start !== 1'b0) $display("FAIL div_enter: got %0d/%0d start=%b exp 0/3 0", disp_mode, disp_val, alu_start); else n_pass++;
  endtask

  task automatic test_abort();
    do_reset();
    press(0);
    press(2);
    tick(); tick();
    press(3);
    n_checks++; if (disp_mode !== 2'd0 || busy !== 1'b0 || disp_val !== 8'd1) $display("FAIL abort_back: got %0d busy=%b val=%0d exp 0 0 1", disp_mode, busy, disp_val); else n_pass++;
    tick(); tick();
    alu_pulse(1'b0, 8'h33);
    tick();
    n_checks++; if (disp_mode !== 2'd0 || disp_val !== 8'd1) $display("FAIL abort_late: got %0d/%h exp 0/01", disp_mode, disp_val); else n_pass++;
    press(2);
    tick(); tick();
    back = 1'b1;
    alu_pulse(1'b0, 8'h44);
    back = 1'b0;
    n_checks++; if (disp_mode !== 2'd0 || disp_val !== 8'd1 || busy !== 1'b0) $display("FAIL abort_coincide: got %0d/%h busy=%b exp 0/01 0", disp_mode, disp_val, busy); else n_pass++;
  endtask

  task automatic test_result_reenter();
    bit ok;
    do_reset();
    for (int i = 0; i < 4; i++) press(0);
    a = 4'd12; b = 4'd10;
    press(2);
    tick();
    exp_q.push_back(alu_ref(3'd4, 4'd12, 4'd10));
    alu_pulse(1'b0, alu_ref(3'd4, 4'd12, 4'd10));
    wait_mode(2'd2, ok);
    exp_v = exp_q.pop_front();
    n_checks++; if (!ok || disp_val !== exp_v) $display("FAIL and_result: got %0d/%h exp 2/%h", disp_mode, disp_val, exp_v); else n_pass++;
    press(0);
    press(1);
    n_checks++; if (disp_mode !== 2'd2 || disp_val !== exp_v) $display("FAIL res_updown: got %0d/%h exp 2/%h", disp_mode, disp_val, exp_v); else n_pass++;
    a = 4'd3; b = 4'd5;
    press(2);
    n_checks++; if (alu_start !== 1'b1 || alu_op !== 3'd4 || alu_a !== 4'd3 || alu_b !== 4'd5) $display("FAIL res_reenter: got start=%b op=%0d a=%0d b=%0d exp 1 4 3 5", alu_start, alu_op, alu_a, alu_b); else n_pass++;
    tick();
    exp_q.push_back(alu_ref(3'd4, 4'd3, 4'd5));
    alu_pulse(1'b0, alu_ref(3'd4, 4'd3, 4'd5));
    wait_mode(2'd2, ok);
    exp_v = exp_q.pop_front();
    n_checks++; if (!ok || disp_val !== exp_v) $display("FAIL res_second: got %0d/%h exp 2/%h", disp_mode, disp_val, exp_v); else n_pass++;
    press(3);
    n_checks++; if (disp_mode !== 2'd0 || disp_val !== 8'd4) $display("FAIL res_back: got %0d/%0d exp 0/4", disp_mode, disp_val); else n_pass++;
  endtask

  task automatic test_reset_midop();
    int starts;
    do_reset();
    press(0);
    tick();
    enter = 1'b1;
    tick();
    tick();
    #2 rst = 1'b0;
    #1;
    n_checks++; if (alu_start !== 1'b0 || busy !== 1'b0 || disp_mode !== 2'd0 || disp_val !== 8'd0 || alu_op !== 3'd0) $display("FAIL midop_async: got start=%b busy=%b mode=%0d val=%h op=%0d exp all 0", alu_start, busy, disp_mode, disp_val, alu_op); else n_pass++;
    tick(); tick();
    rst = 1'b1;
    starts = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (alu_start === 1'b1 || busy === 1'b1) starts++;
    end
    n_checks++; if (starts !== 0) $display("FAIL midop_held: got %0d starts exp 0", starts); else n_pass++;
    enter = 1'b0;
    tick();
    enter = 1'b1;
    tick();
    enter = 1'b0;
    n_checks++; if (alu_start !== 1'b1 || alu_op !== 3'd0) $display("FAIL midop_repress: got start=%b op=%0d exp 1 0", alu_start, alu_op); else n_pass++;
  endtask

  task automatic test_random_ops();
    bit ok;
    logic [2:0] op;
    logic [3:0] ra, rb;
    int steps;
    do_reset();
    for (int n = 0; n < 8; n++) begin
      op = 3'($urandom_range(0, 7));
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(1, 15));
      steps = int'(3'(op - exp_idx));
      for (int s = 0; s < steps; s++) press(0);
      exp_idx = op;
      n_checks++; if (disp_val !== {5'b0, op}) $display("FAIL rnd_sel: got %0d exp %0d", disp_val, op); else n_pass++;
      a = ra; b = rb;
      press(2);
      n_checks++; if (alu_op !== op || alu_a !== ra || alu_b !== rb || alu_start !== 1'b1) $display("FAIL rnd_latch: got op=%0d a=%0d b=%0d start=%b exp %0d %0d %0d 1", alu_op, alu_a, alu_b, alu_start, op, ra, rb); else n_pass++;
      for (int d = 0; d < int'($urandom_range(1, 6)); d++) tick();
      exp_q.push_back(alu_ref(op, ra, rb));
      alu_pulse(1'b0, alu_ref(op, ra, rb));
      wait_mode(2'd2, ok);
      exp_v = exp_q.pop_front();
      n_checks++; if (!ok || disp_val !== exp_v) $display("FAIL rnd_result: got %0d/%h exp 2/%h", disp_mode, disp_val, exp_v); else n_pass++;
      press(3);
    end
  endtask

  // sequence and final report
  initial begin
    exp_idx = 3'd0;
    test_reset();
    test_mul();
    test_menu_wrap();
    test_timeout();
    test_div_err();
    test_abort();
    test_result_reenter();
    test_reset_midop();
    test_random_ops();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
